// File: rtl/alu_multicycle.sv
// Clocked ALU with Z/N/C/V status and a bit-serial variable shifter.
// Single-cycle ops complete on the launch edge; shifts by n>=1 take n extra cycles.
module alu_multicycle #(
    parameter int WIDTH = 64,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [4:0]       fsec,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] fout,
    output logic             done,
    output logic             busy,
    output logic [3:0]       flags
);

    typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [1:0]       op_q, op_d;
    logic [WIDTH-1:0] fout_q, fout_d;
    logic [3:0]       flags_q, flags_d;
    logic             done_q, done_d;

    logic             c_flag;
    logic             is_shift;
    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] ar_x, ar_y;
    logic             ar_cin;
    logic [WIDTH:0]   ar_sum;
    logic [WIDTH-1:0] sc_res;
    logic             sc_c, sc_v;
    logic [WIDTH-1:0] sh_next;
    logic             sh_out;

    assign c_flag   = flags_q[1];
    assign shamt    = B[SHW-1:0];
    assign is_shift = (fsec == 5'h11) || (fsec == 5'h12) || (fsec == 5'h13);

    // Every arithmetic opcode maps onto one adder: x + y + cin.
    always_comb begin
        ar_x   = A;
        ar_y   = '0;
        ar_cin = 1'b0;
        case (fsec)
            5'h00: begin ar_x = '0; ar_y = ~A; ar_cin = 1'b1; end
            5'h01: begin ar_x = '0; ar_y = ~B; ar_cin = 1'b1; end
            5'h02: begin ar_y = B; end
            5'h03: begin ar_y = B; ar_cin = c_flag; end
            5'h04: begin ar_cin = 1'b1; end
            5'h05: begin ar_x = B; ar_y = ~A; ar_cin = 1'b1; end
            5'h06: begin ar_y = ~B; ar_cin = 1'b1; end
            5'h07: begin ar_y = '1; end
            default: ;
        endcase
    end

    assign ar_sum = {1'b0, ar_x} + {1'b0, ar_y} + (WIDTH + 1)'(ar_cin);

    always_comb begin
        sc_res = '0;
        sc_c   = c_flag;
        sc_v   = 1'b0;
        case (fsec)
            5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07: begin
                sc_res = ar_sum[WIDTH-1:0];
                sc_c   = ar_sum[WIDTH];
                sc_v   = (ar_x[WIDTH-1] == ar_y[WIDTH-1]) &&
                         (ar_sum[WIDTH-1] != ar_x[WIDTH-1]);
            end
            5'h08: sc_res = '0;
            5'h09: sc_res = A;
            5'h0A: sc_res = ~A;
            5'h0B: sc_res = ~B;
            5'h0C: sc_res = A & B;
            5'h0D: sc_res = A | B;
            5'h0E: sc_res = A ^ B;
            5'h0F: begin sc_res = A << 1; sc_c = A[WIDTH-1]; end
            5'h10: begin sc_res = A >> 1; sc_c = A[0]; end
            // Zero-length shift: pass A through, carry untouched.
            5'h11, 5'h12, 5'h13: sc_res = A;
            default: sc_res = '0;
        endcase
    end

    always_comb begin
        sh_next = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_out  = work_q[0];
        case (op_q)
            2'b01: begin sh_next = work_q << 1; sh_out = work_q[WIDTH-1]; end
            2'b10: begin sh_next = work_q >> 1; sh_out = work_q[0]; end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        fout_d  = fout_q;
        flags_d = flags_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (is_shift && (shamt != '0)) begin
                        work_d  = A;
                        cnt_d   = shamt;
                        op_d    = fsec[1:0];
                        state_d = SHIFT;
                    end else begin
                        fout_d  = sc_res;
                        flags_d = {(sc_res == '0), sc_res[WIDTH-1], sc_c, sc_v};
                        done_d  = 1'b1;
                    end
                end
            end
            SHIFT: begin
                work_d = sh_next;
                cnt_d  = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    fout_d  = sh_next;
                    flags_d = {(sh_next == '0), sh_next[WIDTH-1], sh_out, 1'b0};
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            work_q  <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            fout_q  <= '0;
            flags_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            fout_q  <= fout_d;
            flags_q <= flags_d;
            done_q  <= done_d;
        end
    end

    assign fout  = fout_q;
    assign flags = flags_q;
    assign done  = done_q;
    assign busy  = (state_q == SHIFT);

endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle: vector table plus shift/reset sequences,
// with a completion scoreboard keyed on done.
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [4:0]  fsec;
    logic [63:0] A, B;
    logic [63:0] fout;
    logic        done, busy;
    logic [3:0]  flags;

    logic        s_start;
    logic [4:0]  s_fsec;
    logic [15:0] s_A, s_B, s_fout;
    logic        s_done, s_busy;
    logic [3:0]  s_flags;

    always #5 clk = ~clk;

    alu_multicycle #(.WIDTH(64)) dut (
        .clk(clk), .rst(rst), .start(start), .fsec(fsec), .A(A), .B(B),
        .fout(fout), .done(done), .busy(busy), .flags(flags)
    );

    alu_multicycle #(.WIDTH(16)) dut16 (
        .clk(clk), .rst(rst), .start(s_start), .fsec(s_fsec), .A(s_A), .B(s_B),
        .fout(s_fout), .done(s_done), .busy(s_busy), .flags(s_flags)
    );

    typedef struct {
        logic [4:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] f;
        logic [3:0]  fl;
    } vec_t;

    typedef struct {
        logic [63:0] f;
        logic [3:0]  fl;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   done_cnt = 0;

    // Scoreboard: every done pops the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            done_cnt++;
            total++;
            if (sb.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: fout=%h flags=%b, required no completion", fout, flags);
            end else begin
                e = sb.pop_front();
                if (fout !== e.f || flags !== e.fl) begin
                    bad++;
                    $display("FAIL op%0d: fout=%h flags=%b, required fout=%h flags=%b",
                             e.tag, fout, flags, e.f, e.fl);
                end else begin
                    $display("op%0d ok: fout=%h flags=%b", e.tag, fout, flags);
                end
            end
            if (busy !== 1'b0) begin
                bad++;
                $display("FAIL busy_with_done: busy=%b, required 0", busy);
            end
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end else begin
            $display("%s ok: %h", name, act);
        end
    endtask

    task automatic push(input logic [63:0] f, input logic [3:0] fl, input int tag);
        exp_t e;
        e.f = f; e.fl = fl; e.tag = tag;
        sb.push_back(e);
    endtask

    // Launch a shift, scramble operands and poke start mid-flight; the
    // negedge index k counts edges from the launch edge (k=1 is just after it).
    task automatic shift_op(input logic [4:0] op, input logic [63:0] a, input logic [63:0] b,
                            input int n, input logic [63:0] f, input logic [3:0] fl,
                            input int tag);
        int k;
        int busy_cnt;
        bit seen;
        @(negedge clk);
        start = 1'b1; fsec = op; A = a; B = b;
        push(f, fl, tag);
        k = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && k < n + 10) begin
            @(negedge clk);
            k++;
            if (k == 1) begin
                start = 1'b0;
                fsec  = 5'h02;
                A     = {$urandom, $urandom};
                B     = {$urandom, $urandom};
            end
            if (n >= 4 && k == 3) start = 1'b1;
            if (n >= 4 && k == 4) start = 1'b0;
            if (busy === 1'b1) busy_cnt++;
            if (done === 1'b1) seen = 1'b1;
        end
        chk($sformatf("shift%0d_done_seen", tag), 64'(seen), 64'd1);
        chk($sformatf("shift%0d_done_edge", tag), 64'(k), 64'(n + 1));
        chk($sformatf("shift%0d_busy_cycles", tag), 64'(busy_cnt), 64'(n));
    endtask

    vec_t vecs[26];

    initial begin
        int base;
        int k;
        bit seen;

        vecs[0]  = '{5'h02, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 64'h0, 4'b1010};
        vecs[1]  = '{5'h03, 64'h0, 64'h0, 64'h1, 4'b0000};
        vecs[2]  = '{5'h06, 64'h8000_0000_0000_0000, 64'h1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vecs[3]  = '{5'h05, 64'h5, 64'h3, 64'hFFFF_FFFF_FFFF_FFFE, 4'b0100};
        vecs[4]  = '{5'h04, 64'h7FFF_FFFF_FFFF_FFFF, 64'h0, 64'h8000_0000_0000_0000, 4'b0101};
        vecs[5]  = '{5'h07, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100};
        vecs[6]  = '{5'h07, 64'h8000_0000_0000_0000, 64'h0, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0011};
        vecs[7]  = '{5'h00, 64'h0, 64'h0, 64'h0, 4'b1010};
        vecs[8]  = '{5'h01, 64'h0, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 4'b0101};
        vecs[9]  = '{5'h0C, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hF000_F000_F000_F000, 4'b0100};
        vecs[10] = '{5'h0D, 64'hF0F0_F0F0_F0F0_F0F0, 64'hFF00_FF00_FF00_FF00, 64'hFFF0_FFF0_FFF0_FFF0, 4'b0100};
        vecs[11] = '{5'h0E, 64'hF0F0_F0F0_F0F0_F0F0, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0, 4'b1000};
        vecs[12] = '{5'h0F, 64'h8000_0000_0000_0001, 64'h0, 64'h2, 4'b0010};
        vecs[13] = '{5'h0A, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0110};
        vecs[14] = '{5'h10, 64'h2, 64'h0, 64'h1, 4'b0000};
        vecs[15] = '{5'h03, 64'h5, 64'h6, 64'hB, 4'b0000};
        vecs[16] = '{5'h09, 64'h0, 64'h7, 64'h0, 4'b1000};
        vecs[17] = '{5'h0B, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 4'b1000};
        vecs[18] = '{5'h08, 64'h5, 64'h5, 64'h0, 4'b1000};
        vecs[19] = '{5'h02, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64'h0, 4'b1011};
        vecs[20] = '{5'h0E, 64'h1, 64'h1, 64'h0, 4'b1010};
        vecs[21] = '{5'h0C, 64'h3, 64'h1, 64'h1, 4'b0010};
        vecs[22] = '{5'h14, 64'h5, 64'h5, 64'h0, 4'b1010};
        vecs[23] = '{5'h11, 64'h1, 64'h0, 64'h1, 4'b0010};
        vecs[24] = '{5'h11, 64'h3, 64'd64, 64'h3, 4'b0010};
        vecs[25] = '{5'h03, 64'h1, 64'h1, 64'h3, 4'b0000};

        rst = 1'b1; start = 1'b0; fsec = '0; A = '0; B = '0;
        s_start = 1'b0; s_fsec = '0; s_A = '0; s_B = '0;
        repeat (3) @(negedge clk);
        chk("reset_fout", fout, 64'h0);
        chk("reset_flags", 64'(flags), 64'h0);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_done", 64'(done), 64'h0);
        rst = 1'b0;

        // Table, issued back-to-back with start held high.
        base = done_cnt;
        for (int i = 0; i < 26; i++) begin
            @(negedge clk);
            start = 1'b1; fsec = vecs[i].op; A = vecs[i].a; B = vecs[i].b;
            push(vecs[i].f, vecs[i].fl, i);
        end
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("table_done_count", 64'(done_cnt - base), 64'd26);

        shift_op(5'h13, 64'h8000_0000_0000_0001, 64'd63, 63, 64'hFFFF_FFFF_FFFF_FFFF, 4'b0100, 100);
        shift_op(5'h11, 64'h0800_0000_0000_0001, 64'd5, 5, 64'h20, 4'b0010, 101);
        shift_op(5'h12, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1, 64'h7FFF_FFFF_FFFF_FFFF, 4'b0010, 102);
        shift_op(5'h12, 64'h18, 64'd4, 4, 64'h1, 4'b0010, 103);

        // Reset in the middle of a shift: nothing completes.
        @(negedge clk);
        start = 1'b1; fsec = 5'h11; A = 64'h1; B = 64'd10;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        chk("midshift_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_shift_busy", 64'(busy), 64'h0);
        chk("rst_shift_done", 64'(done), 64'h0);
        chk("rst_shift_fout", fout, 64'h0);
        chk("rst_shift_flags", 64'(flags), 64'h0);
        repeat (12) @(negedge clk);

        // Carry was cleared by reset, so add-with-carry is a plain add.
        start = 1'b1; fsec = 5'h03; A = 64'h2; B = 64'h3;
        push(64'h5, 4'b0000, 200);
        @(negedge clk);
        start = 1'b0;

        // 16-bit instance: logical right shift by 15.
        s_start = 1'b1; s_fsec = 5'h12; s_A = 16'h8001; s_B = 16'd15;
        k = 0; seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (k == 1) begin s_start = 1'b0; s_A = 16'h1234; s_B = 16'h0003; end
            if (s_done === 1'b1) seen = 1'b1;
        end
        chk("w16_done_seen", 64'(seen), 64'd1);
        chk("w16_done_edge", 64'(k), 64'd16);
        chk("w16_fout", 64'(s_fout), 64'h1);
        chk("w16_flags", 64'(s_flags), 64'b0000);

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
